// File: rtl/fp_pkg.sv
// Shared types for the pipelined floating-point adder/subtractor.
// Stage payload structs are sized by the package widths below; keep them equal to the top-level parameters.
package fp_pkg;

    localparam int PKG_EXP_W  = 4;
    localparam int PKG_FRAC_W = 8;
    localparam int GRS_W      = 3;
    localparam int ALN_W      = PKG_FRAC_W + GRS_W;
    localparam int SUM_W      = ALN_W + 1;

    // Operands after swap/align: big operand untouched, small one shifted with guard/round/sticky.
    typedef struct packed {
        logic                  valid;
        logic                  sign;
        logic                  eff_sub;
        logic [PKG_EXP_W-1:0]  exp;
        logic [PKG_FRAC_W-1:0] big_frac;
        logic [ALN_W-1:0]      small_aln;
    } s1_t;

    typedef struct packed {
        logic                 valid;
        logic                 sign;
        logic [PKG_EXP_W-1:0] exp;
        logic [SUM_W-1:0]     sum;
    } s2_t;

    typedef struct packed {
        logic                  sign;
        logic [PKG_EXP_W-1:0]  exp;
        logic [PKG_FRAC_W-1:0] frac;
        logic                  ovf;
        logic                  uf;
        logic                  zero;
        logic                  inexact;
    } res_t;

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter: count is the number of zeros above the highest set bit, W when all zero.
module fp_lzc #(
    parameter int W = 8
) (
    input  logic [W-1:0]             value,
    output logic [$clog2(W+1)-1:0]   count,
    output logic                     all_zero
);

    localparam int CW = $clog2(W + 1);

    // Scanning upward lets the highest set bit have the last word.
    always_comb begin
        count = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (value[i]) begin
                count = CW'(W - 1 - i);
            end
        end
    end

    assign all_zero = ~|value;

endmodule

// File: rtl/fp_addsub_pipe.sv
// Three-stage floating-point add/subtract: swap/align, add/sub, normalise/round/pack.
// All stages advance together whenever the output register is empty or being drained.
module fp_addsub_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W  = PKG_EXP_W,
    parameter int FRAC_W = PKG_FRAC_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              op,
    input  logic              a_sign,
    input  logic [EXP_W-1:0]  a_exp,
    input  logic [FRAC_W-1:0] a_frac,
    input  logic              b_sign,
    input  logic [EXP_W-1:0]  b_exp,
    input  logic [FRAC_W-1:0] b_frac,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              r_sign,
    output logic [EXP_W-1:0]  r_exp,
    output logic [FRAC_W-1:0] r_frac,
    output logic              flag_ovf,
    output logic              flag_uf,
    output logic              flag_zero,
    output logic              flag_inexact
);

    localparam int LZ_W = $clog2(ALN_W + 1);
    localparam int XW   = ((EXP_W > LZ_W) ? EXP_W : LZ_W) + 2;
    localparam int SH_W = 2 * FRAC_W + 4;
    localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);

    logic adv;
    s1_t  s1_d, s1_q;
    s2_t  s2_d, s2_q;
    res_t s3_d, res_q;
    logic out_valid_q;

    assign adv      = !out_valid_q | out_ready;
    assign in_ready = adv;

    // Stage 1: operands with a cleared leading bit count as zero magnitude so they always lose the compare.
    logic                  a_zero, b_zero, a_s, b_s, swap;
    logic [EXP_W-1:0]      a_e, b_e, big_e, sml_e, diff;
    logic [FRAC_W-1:0]     a_f, b_f, big_f, sml_f;
    logic [SH_W-1:0]       shifted;
    logic [ALN_W-1:0]      sml_aln;

    always_comb begin
        s1_d    = '0;
        a_zero  = !a_frac[FRAC_W-1];
        b_zero  = !b_frac[FRAC_W-1];
        a_e     = a_zero ? '0 : a_exp;
        a_f     = a_zero ? '0 : a_frac;
        b_e     = b_zero ? '0 : b_exp;
        b_f     = b_zero ? '0 : b_frac;
        a_s     = a_sign;
        b_s     = b_sign ^ op;
        swap    = {b_e, b_f} > {a_e, a_f};
        big_e   = swap ? b_e : a_e;
        big_f   = swap ? b_f : a_f;
        sml_e   = swap ? a_e : b_e;
        sml_f   = swap ? a_f : b_f;
        diff    = big_e - sml_e;
        shifted = {sml_f, {(FRAC_W + 4){1'b0}}} >> diff;
        if (32'(diff) >= FRAC_W + 2) begin
            sml_aln = {{(ALN_W - 1){1'b0}}, |sml_f};
        end else begin
            sml_aln = {shifted[SH_W-1 -: FRAC_W+2], |shifted[FRAC_W+1:0]};
        end
        s1_d.valid     = in_valid;
        s1_d.sign      = swap ? b_s : a_s;
        s1_d.eff_sub   = a_s ^ b_s;
        s1_d.exp       = big_e;
        s1_d.big_frac  = big_f;
        s1_d.small_aln = sml_aln;
    end

    // Stage 2: big >= small in magnitude, so the subtraction never goes negative.
    logic [SUM_W-1:0] big_ext, sml_ext;

    always_comb begin
        s2_d       = '0;
        big_ext    = {1'b0, s1_q.big_frac, {GRS_W{1'b0}}};
        sml_ext    = {1'b0, s1_q.small_aln};
        s2_d.valid = s1_q.valid;
        s2_d.sign  = s1_q.sign;
        s2_d.exp   = s1_q.exp;
        s2_d.sum   = s1_q.eff_sub ? (big_ext - sml_ext) : (big_ext + sml_ext);
    end

    logic [LZ_W-1:0] lz;
    logic            lz_zero;

    fp_lzc #(.W(ALN_W)) u_lzc (
        .value    (s2_q.sum[ALN_W-1:0]),
        .count    (lz),
        .all_zero (lz_zero)
    );

    // Stage 3: exponents are tracked signed and wider so underflow and overflow are both visible.
    logic                     carry, is_zero, grd, rnd_b, stk, rnd;
    logic [ALN_W-1:0]         nrm;
    logic [FRAC_W-1:0]        frac_n, frac_r;
    logic [FRAC_W:0]          frac_sum;
    logic signed [XW-1:0]     exp_n, exp_r;

    always_comb begin
        s3_d    = '0;
        carry   = s2_q.sum[SUM_W-1];
        is_zero = !carry & lz_zero;
        if (carry) begin
            nrm   = {s2_q.sum[SUM_W-1:2], s2_q.sum[1] | s2_q.sum[0]};
            exp_n = XW'(s2_q.exp) + XW'(1);
        end else begin
            nrm   = s2_q.sum[ALN_W-1:0] << lz;
            exp_n = XW'(s2_q.exp) - XW'(lz);
        end
        frac_n   = nrm[ALN_W-1:GRS_W];
        grd      = nrm[2];
        rnd_b    = nrm[1];
        stk      = nrm[0];
        rnd      = grd & (rnd_b | stk | frac_n[0]);
        frac_sum = {1'b0, frac_n} + {{FRAC_W{1'b0}}, rnd};
        if (frac_sum[FRAC_W]) begin
            frac_r = {1'b1, {(FRAC_W - 1){1'b0}}};
            exp_r  = exp_n + XW'(1);
        end else begin
            frac_r = frac_sum[FRAC_W-1:0];
            exp_r  = exp_n;
        end

        if (!s2_q.valid) begin
            s3_d = '0;
        end else if (is_zero) begin
            s3_d.zero = 1'b1;
        end else if (exp_n < 0) begin
            s3_d.uf   = 1'b1;
            s3_d.zero = 1'b1;
        end else if (exp_r > EXP_MAX) begin
            s3_d.sign    = s2_q.sign;
            s3_d.exp     = '1;
            s3_d.frac    = '1;
            s3_d.ovf     = 1'b1;
            s3_d.inexact = grd | rnd_b | stk;
        end else begin
            s3_d.sign    = s2_q.sign;
            s3_d.exp     = exp_r[EXP_W-1:0];
            s3_d.frac    = frac_r;
            s3_d.inexact = grd | rnd_b | stk;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q        <= '0;
            s2_q        <= '0;
            res_q       <= '0;
            out_valid_q <= 1'b0;
        end else if (adv) begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            res_q       <= s3_d;
            out_valid_q <= s2_q.valid;
        end
    end

    assign out_valid    = out_valid_q;
    assign r_sign       = res_q.sign;
    assign r_exp        = res_q.exp;
    assign r_frac       = res_q.frac;
    assign flag_ovf     = res_q.ovf;
    assign flag_uf      = res_q.uf;
    assign flag_zero    = res_q.zero;
    assign flag_inexact = res_q.inexact;

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed-vector bench for fp_addsub_pipe (EXP_W=4, FRAC_W=8): table of hand-computed results
// plus stall/drain and mid-flight reset sequences.
module tb_fp_addsub_pipe;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid, in_ready, op;
    logic       a_sign, b_sign;
    logic [3:0] a_exp, b_exp;
    logic [7:0] a_frac, b_frac;
    logic       out_valid, out_ready;
    logic       r_sign;
    logic [3:0] r_exp;
    logic [7:0] r_frac;
    logic       flag_ovf, flag_uf, flag_zero, flag_inexact;

    typedef struct packed {
        logic       sign;
        logic [3:0] exp;
        logic [7:0] frac;
        logic       ovf;
        logic       uf;
        logic       zero;
        logic       inexact;
    } tb_res_t;

    typedef struct {
        logic       op;
        logic       as;
        logic [3:0] ae;
        logic [7:0] af;
        logic       bs;
        logic [3:0] be;
        logic [7:0] bf;
        tb_res_t    expect_res;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs[NVEC];
    int   tests  = 0;
    int   failed = 0;

    fp_addsub_pipe #(.EXP_W(4), .FRAC_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .op           (op),
        .a_sign       (a_sign),
        .a_exp        (a_exp),
        .a_frac       (a_frac),
        .b_sign       (b_sign),
        .b_exp        (b_exp),
        .b_frac       (b_frac),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .r_sign       (r_sign),
        .r_exp        (r_exp),
        .r_frac       (r_frac),
        .flag_ovf     (flag_ovf),
        .flag_uf      (flag_uf),
        .flag_zero    (flag_zero),
        .flag_inexact (flag_inexact)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // fl packs {ovf, uf, zero, inexact}
    function automatic vec_t mkv(input logic o, input logic as, input logic [3:0] ae, input logic [7:0] af,
                                 input logic bs, input logic [3:0] be, input logic [7:0] bf,
                                 input logic rs, input logic [3:0] re, input logic [7:0] rf, input logic [3:0] fl);
        vec_t v;
        v.op = o; v.as = as; v.ae = ae; v.af = af; v.bs = bs; v.be = be; v.bf = bf;
        v.expect_res = {rs, re, rf, fl};
        return v;
    endfunction

    function automatic tb_res_t got();
        return {r_sign, r_exp, r_frac, flag_ovf, flag_uf, flag_zero, flag_inexact};
    endfunction

    task automatic checkOutput(input string name, input tb_res_t act, input tb_res_t req);
        tests++;
        if (act !== req) begin
            failed++;
            $display("[TB] FAIL %s: got s=%0b e=%h f=%h ovf/uf/z/inx=%b%b%b%b, expected s=%0b e=%h f=%h ovf/uf/z/inx=%b%b%b%b",
                     name, act.sign, act.exp, act.frac, act.ovf, act.uf, act.zero, act.inexact,
                     req.sign, req.exp, req.frac, req.ovf, req.uf, req.zero, req.inexact);
        end
    endtask

    task automatic checkValue(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        op     = v.op;
        a_sign = v.as; a_exp = v.ae; a_frac = v.af;
        b_sign = v.bs; b_exp = v.be; b_frac = v.bf;
    endtask

    task automatic runVector(input int i);
        int lat;
        @(negedge clk);
        applyStimulus(vecs[i]);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkValue($sformatf("latency[%0d]", i), lat, 3);
        checkOutput($sformatf("vec[%0d]", i), got(), vecs[i].expect_res);
    endtask

    initial begin
        int acc, rdy, j, cyc, extra;

        vecs[0]  = mkv(0, 0,4'h3,8'h80, 0,4'h3,8'h80, 0,4'h4,8'h80, 4'b0000);
        vecs[1]  = mkv(0, 0,4'h5,8'h83, 0,4'h5,8'h80, 0,4'h6,8'h82, 4'b0001);
        vecs[2]  = mkv(0, 0,4'h5,8'h81, 0,4'h5,8'h80, 0,4'h6,8'h80, 4'b0001);
        vecs[3]  = mkv(0, 0,4'hF,8'hFF, 0,4'hF,8'hFF, 0,4'hF,8'hFF, 4'b1000);
        vecs[4]  = mkv(1, 0,4'h3,8'h80, 0,4'h3,8'h80, 0,4'h0,8'h00, 4'b0010);
        vecs[5]  = mkv(1, 0,4'h0,8'hC0, 0,4'h0,8'h80, 0,4'h0,8'h00, 4'b0110);
        vecs[6]  = mkv(0, 0,4'h4,8'h80, 0,4'h2,8'h80, 0,4'h4,8'hA0, 4'b0000);
        vecs[7]  = mkv(1, 0,4'h5,8'h80, 0,4'h4,8'hC0, 0,4'h3,8'h80, 4'b0000);
        vecs[8]  = mkv(1, 0,4'h3,8'h80, 0,4'h4,8'h80, 1,4'h3,8'h80, 4'b0000);
        vecs[9]  = mkv(0, 0,4'hA,8'h80, 0,4'h0,8'hFF, 0,4'hA,8'h80, 4'b0001);
        vecs[10] = mkv(0, 0,4'h4,8'hFF, 0,4'h0,8'hF0, 0,4'h5,8'h87, 4'b0000);
        vecs[11] = mkv(0, 0,4'h8,8'hFF, 0,4'h0,8'h80, 0,4'h9,8'h80, 4'b0001);
        vecs[12] = mkv(0, 0,4'h7,8'h40, 1,4'h2,8'h90, 1,4'h2,8'h90, 4'b0000);
        vecs[13] = mkv(0, 1,4'h5,8'h00, 1,4'h6,8'h10, 0,4'h0,8'h00, 4'b0010);
        vecs[14] = mkv(0, 0,4'hF,8'hFF, 0,4'h7,8'h80, 0,4'hF,8'hFF, 4'b1001);
        vecs[15] = mkv(0, 1,4'hF,8'h80, 1,4'hF,8'h80, 1,4'hF,8'hFF, 4'b1000);
        vecs[16] = mkv(1, 0,4'h4,8'h80, 1,4'h4,8'h80, 0,4'h5,8'h80, 4'b0000);

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        applyStimulus(vecs[0]);
        repeat (2) @(posedge clk);
        #1;
        checkValue("reset out_valid", int'(out_valid), 0);
        checkValue("reset in_ready", int'(in_ready), 1);
        checkOutput("reset result", got(), '0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            runVector(i);
        end

        // Stall: output blocked, five offered inputs, only three fit in the pipeline.
        repeat (3) @(negedge clk);
        out_ready = 1'b0;
        acc = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            applyStimulus(vecs[acc]);
            in_valid = 1'b1;
            rdy = int'(in_ready);
            @(posedge clk);
            if (rdy != 0) acc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        checkValue("stall accepted", acc, 3);
        checkValue("stall in_ready", int'(in_ready), 0);
        repeat (3) @(negedge clk);
        checkValue("stall out_valid", int'(out_valid), 1);
        checkOutput("stall head", got(), vecs[0].expect_res);

        out_ready = 1'b1;
        j = 0;
        cyc = 0;
        while (j < 3 && cyc < 20) begin
            if (out_valid) begin
                checkOutput($sformatf("drain[%0d]", j), got(), vecs[j].expect_res);
                j++;
            end
            @(negedge clk);
            cyc++;
        end
        checkValue("drain count", j, 3);
        extra = 0;
        repeat (5) begin
            if (out_valid) extra++;
            @(negedge clk);
        end
        checkValue("drain no duplicate", extra, 0);

        // Reset while two operations are in flight.
        @(negedge clk);
        applyStimulus(vecs[6]);
        in_valid = 1'b1;
        @(negedge clk);
        applyStimulus(vecs[7]);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        checkValue("pre-reset out_valid", int'(out_valid), 1);
        reset = 1'b1;
        #1;
        checkValue("async reset out_valid", int'(out_valid), 0);
        checkValue("async reset in_ready", int'(in_ready), 1);
        checkOutput("async reset result", got(), '0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        checkValue("no stale after reset", extra, 0);
        runVector(8);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/fp_addsub_pipe.md
FP_ADDSUB_PIPE -- requirements
Module: fp_addsub_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 4, exponent width (unsigned, biased by user; 0 = smallest).
REQ-002 SHALL have parameter FRAC_W, default 8, fraction width with explicit leading one (MSB=1 when normalised).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports in_valid input 1, in_ready output 1: input handshake.
REQ-006 SHALL have port op  input  1  0 = a+b, 1 = a-b.
REQ-007 SHALL have ports a_sign/b_sign input 1, a_exp/b_exp input EXP_W, a_frac/b_frac input FRAC_W: operands.
REQ-008 SHALL have ports out_valid output 1, out_ready input 1: output handshake.
REQ-009 SHALL have ports r_sign output 1, r_exp output EXP_W, r_frac output FRAC_W: result.
REQ-010 SHALL have ports flag_ovf, flag_uf, flag_zero, flag_inexact, each output 1, aligned with result.

Function
REQ-011 SHALL transfer an input when in_valid & in_ready and an output when out_valid & out_ready.
REQ-012 SHALL be a 3-stage pipeline (S1 swap/align, S2 add/sub, S3 normalise/round/pack); latency exactly 3 cycles with no stall.
REQ-013 SHALL advance all stages together when adv = !out_valid | out_ready; in_ready = adv, combinational, no dependency on in_valid.
REQ-014 SHALL keep stage valid bits; bubbles propagate, results leave in acceptance order, none dropped or duplicated.
REQ-015 S1 SHALL invert b_sign when op=1, order operands by {exp,frac} magnitude (ties: a is big), and take effective sign of big operand.
REQ-016 S1 SHALL right-shift the small fraction by exp difference into FRAC_W+3 bits (guard, round, sticky = OR of all lost bits); shift >= FRAC_W+2 leaves only sticky.
REQ-017 S2 SHALL add if effective signs equal, else subtract small from big, in FRAC_W+4 bits (carry bit).
REQ-018 S3 on carry SHALL shift right 1 (LSB folded into sticky) and increment exponent.
REQ-019 S3 otherwise SHALL left-normalise by leading-zero count, decrementing exponent.
REQ-020 S3 SHALL round to nearest, ties to even, using guard/round/sticky; rounding carry-out renormalises (frac = 1000..0, exp+1).
REQ-021 flag_inexact SHALL be 1 when any of guard/round/sticky nonzero after normalisation.
REQ-022 Exponent exceeding 2^EXP_W-1 SHALL saturate to exp all-ones, frac all-ones, sign kept, flag_ovf=1.
REQ-023 Normalisation requiring exponent below 0 SHALL flush to exp 0, frac 0, sign 0, flag_uf=1.
REQ-024 Exact zero sum SHALL give sign 0, exp 0, frac 0, flag_zero=1 (also set on underflush).
REQ-025 Operand with frac MSB=0 SHALL be treated as zero; both zero -> zero result, flag_zero=1.
REQ-026 Outputs SHALL hold stable while out_valid & !out_ready.

Reset
REQ-027 reset SHALL asynchronously clear all stage valid bits; out_valid=0, all result and flag outputs 0; in_ready=1 after reset.
REQ-028 reset mid-operation SHALL discard all in-flight operations; first post-reset output is first post-reset input.

Structure
REQ-029 Shared package fp_pkg SHALL hold stage-payload struct typedefs (parametrised by EXP_W/FRAC_W via localparams) and GRS width constant.
REQ-030 Leading-zero counter SHALL be sub-module fp_lzc (parameter W, output count, all-zero flag).

Verification (EXP_W=4, FRAC_W=8)
REQ-031 (0,3,80)+(0,3,80), op=0 -> (0,4,80), all flags 0, out_valid 3 cycles after accept.
REQ-032 (0,5,83)+(0,5,80) -> (0,6,82) inexact=1 (tie rounds to even); (0,5,81)+(0,5,80) -> (0,6,80) inexact=1.
REQ-033 (0,F,FF)+(0,F,FF) -> (0,F,FF) flag_ovf=1; (0,3,80)-(0,3,80), op=1 -> (0,0,00) flag_zero=1.
REQ-034 (0,0,C0)-(0,0,80) -> (0,0,00) flag_uf=1, flag_zero=1.
REQ-035 out_ready=0, 5 back-to-back inputs -> 3 accepted, in_ready=0; release -> results in order, no loss.
REQ-036 reset asserted 1 cycle after 2 accepts -> out_valid=0 immediately; no stale results after release.
